fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/toy_pkg.sv | 6 +
 rtl/fetch_queue.sv | 48 ++++
 rtl/fetch_unit.sv | 48 ++++
 tb/tb_fetch_unit.sv | 133 +++++++++++++
 4 files changed

// File: rtl/toy_pkg.sv
// toy_pkg: shared CPU width constants and fetch reset address
package toy_pkg;
  localparam int TOY_ADDR_W = 12;
  localparam int TOY_INST_W = 16;
  localparam int TOY_RESET_PC = 0;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular {pc,inst} buffer; push/pop/flush in, head entry and count out
module fetch_queue #(
  parameter int AW = 12,
  parameter int IW = 16,
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [AW-1:0] wr_pc,
  input  logic [IW-1:0] wr_inst,
  output logic [AW-1:0] head_pc,
  output logic [IW-1:0] head_inst,
  output logic [CW-1:0] count
);
  logic [AW-1:0] pc_mem [DEPTH];
  logic [IW-1:0] inst_mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  assign head_pc = pc_mem[rptr];
  assign head_inst = inst_mem[rptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i] <= '0;
        inst_mem[i] <= '0;
      end
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[wptr] <= wr_pc;
        inst_mem[wptr] <= wr_inst;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC + queue; imem_addr/imem_inst to memory, redirect/halt control, inst_valid/ready/out/pc/count to decode
module fetch_unit
  import toy_pkg::*;
#(
  parameter int ADDR_W = TOY_ADDR_W,
  parameter int INST_W = TOY_INST_W,
  parameter int DEPTH = 2,
  parameter int RESET_PC = TOY_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [INST_W-1:0]        imem_inst,
  input  logic                     redirect_valid,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     halt,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [INST_W-1:0]        inst_out,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [ADDR_W-1:0] fpc;
  logic push, pop;
  assign imem_addr = fpc;
  assign inst_valid = count != '0;
  assign pop = inst_valid && inst_ready;
  assign push = !halt && !redirect_valid && (count < FULL || pop);
  always_ff @(posedge clk) begin
    if (rst) fpc <= ADDR_W'(RESET_PC);
    else if (redirect_valid) fpc <= redirect_pc;
    else if (push) fpc <= fpc + 1'b1;
  end
  fetch_queue #(.AW(ADDR_W), .IW(INST_W), .DEPTH(DEPTH)) u_queue (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .wr_pc(fpc),
    .wr_inst(imem_inst),
    .head_pc(inst_pc),
    .head_inst(inst_out),
    .count(count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed-vector self-checking bench for fetch_unit
module tb_fetch_unit;
  logic clk = 0;
  logic rst;
  logic [11:0] imem_addr;
  logic [15:0] imem_inst;
  logic redirect_valid;
  logic [11:0] redirect_pc;
  logic halt;
  logic inst_valid;
  logic inst_ready;
  logic [15:0] inst_out;
  logic [11:0] inst_pc;
  logic [1:0] count;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign imem_inst = 16'(imem_addr) + 16'h100;
  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_inst(imem_inst),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .halt(halt),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .inst_out(inst_out),
    .inst_pc(inst_pc),
    .count(count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input int pc, input int cnt);
    check({tag, " valid"}, 32'(inst_valid), 1);
    check({tag, " pc"}, 32'(inst_pc), 32'(pc));
    check({tag, " inst"}, 32'(inst_out), 32'(16'(pc + 'h100)));
    check({tag, " count"}, 32'(count), 32'(cnt));
  endtask
  task automatic idle(input string tag, input int addr);
    check({tag, " valid"}, 32'(inst_valid), 0);
    check({tag, " count"}, 32'(count), 0);
    check({tag, " addr"}, 32'(imem_addr), 32'(addr));
  endtask
  initial begin
    rst = 1; halt = 0; redirect_valid = 0; redirect_pc = 0; inst_ready = 1;
    step();
    step();
    idle("reset", 0);
    check("reset inst", 32'(inst_out), 0);
    check("reset pc", 32'(inst_pc), 0);
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      head("stream", i, 1);
      check("stream addr", 32'(imem_addr), 32'(i + 1));
    end
    inst_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      head("stall", 5, 2);
      check("stall addr", 32'(imem_addr), 7);
    end
    inst_ready = 1;
    for (int i = 6; i < 10; i++) begin
      step();
      head("resume", i, 2);
    end
    redirect_valid = 1; redirect_pc = 12'h7F0;
    step();
    idle("redirect", 'h7F0);
    redirect_valid = 0;
    step();
    head("after redirect", 'h7F0, 1);
    redirect_valid = 1; redirect_pc = 12'h123;
    step();
    idle("redir a", 'h123);
    redirect_pc = 12'hFFE;
    step();
    idle("redir b", 'hFFE);
    redirect_valid = 0;
    step();
    head("wrap0", 'hFFE, 1);
    step();
    head("wrap1", 'hFFF, 1);
    step();
    head("wrap2", 'h000, 1);
    step();
    head("wrap3", 'h001, 1);
    halt = 1; redirect_valid = 1; redirect_pc = 12'h050;
    step();
    idle("halt redirect", 'h050);
    redirect_valid = 0;
    step();
    step();
    idle("halted", 'h050);
    halt = 0; inst_ready = 0;
    step();
    step();
    head("fill", 'h050, 2);
    halt = 1; inst_ready = 1;
    step();
    head("drain1", 'h051, 1);
    check("drain1 addr", 32'(imem_addr), 'h052);
    step();
    idle("drain2", 'h052);
    step();
    idle("drain3", 'h052);
    halt = 0;
    step();
    head("unhalt", 'h052, 1);
    inst_ready = 0;
    step();
    head("refill", 'h052, 2);
    rst = 1; redirect_valid = 1; redirect_pc = 12'h333;
    step();
    idle("rst over redirect", 0);
    check("rst inst", 32'(inst_out), 0);
    check("rst pc", 32'(inst_pc), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
